// File: rtl/lpf_frame_writer.sv
// Write side of the LPF frame-buffer port: packs raster pixel pairs into 36-bit words and
// streams them to memory_interface through a small word FIFO, one outstanding write at a time.
module lpf_frame_writer #(
   parameter int WIDTH      = 640,
   parameter int HEIGHT     = 480,
   parameter int FIFO_DEPTH = 4,
   localparam int XW        = $clog2(WIDTH),
   localparam int YW        = $clog2(HEIGHT),
   localparam int PW        = 18,
   localparam int MW        = 2 * PW
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          frame_flag,
   input  logic [PW-1:0] pixel,
   input  logic          pixel_flag,
   output logic          lpf_flag,
   output logic          lpf_wr,
   output logic [XW-1:0] lpf_x,
   output logic [YW-1:0] lpf_y,
   output logic [MW-1:0] lpf_pixel_write,
   input  logic          done_lpf,
   output logic          frame_done,
   output logic          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 1 + XW + YW + MW;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t        state, state_nxt;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [PW-1:0] hi;
   logic          frame_end;
   logic          cur_last;

   logic [EW-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   logic          accept, line_end, last_px;
   logic          push_req, push, pop, issue, ack;
   logic [EW-1:0] entry, head;

   // x[0] doubles as the half-word flag: an odd x means the hi half is already latched.
   assign accept   = pixel_flag && !frame_flag && !frame_end;
   assign line_end = (x == XW'(WIDTH - 1));
   assign last_px  = line_end && (y == YW'(HEIGHT - 1));
   assign push_req = accept && x[0];
   assign pop      = ack && (count != '0) && !frame_flag;
   assign push     = push_req && ((count != CW'(FIFO_DEPTH)) || pop);
   assign entry    = {last_px, x - XW'(1), y, hi, pixel};
   assign head     = fifo_mem[rd_ptr];

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      ack       = 1'b0;
      case (state)
         IDLE: begin
            if ((count != '0) && !frame_flag) begin
               state_nxt = ISSUE;
               issue     = 1'b1;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (done_lpf) begin
               state_nxt = IDLE;
               ack       = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Request outputs are loaded once at issue and held until the next issue.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lpf_flag        <= 1'b0;
         lpf_wr          <= 1'b0;
         lpf_x           <= '0;
         lpf_y           <= '0;
         lpf_pixel_write <= '0;
         cur_last        <= 1'b0;
         frame_done      <= 1'b0;
      end else begin
         lpf_flag   <= issue;
         lpf_wr     <= issue;
         frame_done <= ack && cur_last && !frame_flag;
         if (issue)           {cur_last, lpf_x, lpf_y, lpf_pixel_write} <= head;
         else if (frame_flag) cur_last <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x         <= '0;
         y         <= '0;
         hi        <= '0;
         frame_end <= 1'b0;
         overflow  <= 1'b0;
      end else if (frame_flag) begin
         x         <= '0;
         y         <= '0;
         hi        <= '0;
         frame_end <= 1'b0;
         overflow  <= 1'b0;
      end else if (accept) begin
         if (!x[0])             hi        <= pixel;
         if (push_req && !push) overflow  <= 1'b1;
         if (last_px)           frame_end <= 1'b1;
         // Counters advance even when a word is dropped so later addresses stay aligned.
         if (line_end) begin
            x <= '0;
            y <= y + YW'(1);
         end else begin
            x <= x + XW'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (frame_flag) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= entry;
   end

endmodule

// File: tb/tb_lpf_frame_writer.sv
// Scoreboard bench for lpf_frame_writer: stimulus queues expected writes, a negedge monitor
// pops and compares each lpf_flag request; a responder process models memory_interface acks.
module tb_lpf_frame_writer;

   localparam int WIDTH  = 640;
   localparam int HEIGHT = 4;
   localparam int XW     = 10;
   localparam int YW     = 2;
   localparam int MW     = 36;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          frame_flag = 1'b0;
   logic [17:0]   pixel = '0;
   logic          pixel_flag = 1'b0;
   logic          done_lpf;
   logic          lpf_flag, lpf_wr, frame_done, overflow;
   logic [XW-1:0] lpf_x;
   logic [YW-1:0] lpf_y;
   logic [MW-1:0] lpf_pixel_write;

   logic auto_done = 1'b0;
   logic man_done  = 1'b0;
   bit   auto_ack  = 1'b0;
   int   ack_delay = 1;
   assign done_lpf = auto_done | man_done;

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [MW-1:0] d;
   } wr_t;

   wr_t  exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   flag_cnt = 0;
   int   last_flag_cyc = -1;
   int   fd_cnt = 0;

   lpf_frame_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .FIFO_DEPTH(4)) dut (
      .clock(clock), .reset(reset), .frame_flag(frame_flag), .pixel(pixel),
      .pixel_flag(pixel_flag), .lpf_flag(lpf_flag), .lpf_wr(lpf_wr), .lpf_x(lpf_x),
      .lpf_y(lpf_y), .lpf_pixel_write(lpf_pixel_write), .done_lpf(done_lpf),
      .frame_done(frame_done), .overflow(overflow)
   );

   initial forever #5 clock = ~clock;
   initial forever begin
      @(posedge clock);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [17:0] pv(input int i);
      return 18'((i * 37 + 11) ^ (i << 9));
   endfunction

   function automatic void expect_wr(input int x, input int y, input logic [MW-1:0] d);
      wr_t w;
      w.x = XW'(x);
      w.y = YW'(y);
      w.d = d;
      exp_q.push_back(w);
   endfunction

   // Memory-side responder: one done_lpf strobe ack_delay cycles after each request.
   initial forever begin
      @(negedge clock);
      if (lpf_flag && auto_ack && !reset) begin
         repeat (ack_delay) @(posedge clock);
         #1 auto_done = 1'b1;
         @(posedge clock);
         #1 auto_done = 1'b0;
      end
   end

   // Monitor: scoreboard compare, hold stability while outstanding, frame_done timing.
   initial begin
      wr_t  e;
      wr_t  held;
      bit   hold_active;
      logic prev_done;
      hold_active = 1'b0;
      prev_done   = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            hold_active = 1'b0;
            prev_done   = 1'b0;
         end else begin
            if (hold_active) begin
               check("hold_x", 64'(lpf_x), 64'(held.x));
               check("hold_y", 64'(lpf_y), 64'(held.y));
               check("hold_data", 64'(lpf_pixel_write), 64'(held.d));
               if (done_lpf) hold_active = 1'b0;
            end
            if (lpf_flag) begin
               flag_cnt++;
               last_flag_cyc = cyc;
               check("lpf_wr", 64'(lpf_wr), 64'd1);
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_write actual x=%0d y=%0d data=%0h required none",
                           lpf_x, lpf_y, lpf_pixel_write);
               end else begin
                  e = exp_q.pop_front();
                  check("wr_x", 64'(lpf_x), 64'(e.x));
                  check("wr_y", 64'(lpf_y), 64'(e.y));
                  check("wr_data", 64'(lpf_pixel_write), 64'(e.d));
               end
               held.x = lpf_x;
               held.y = lpf_y;
               held.d = lpf_pixel_write;
               hold_active = 1'b1;
            end
            if (frame_done) begin
               fd_cnt++;
               check("frame_done_after_ack", 64'(prev_done), 64'd1);
            end
            prev_done = done_lpf;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic px(input logic [17:0] v);
      pixel      = v;
      pixel_flag = 1'b1;
      tick(1);
      pixel_flag = 1'b0;
   endtask

   task automatic pulse_ff();
      frame_flag = 1'b1;
      tick(1);
      frame_flag = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick(1);
         n++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
      tick(8);
   endtask

   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int c, fc0, fd0, n;

      // Reset state
      tick(3);
      check("rst_lpf_flag", 64'(lpf_flag), 64'd0);
      check("rst_lpf_wr", 64'(lpf_wr), 64'd0);
      check("rst_lpf_x", 64'(lpf_x), 64'd0);
      check("rst_lpf_y", 64'(lpf_y), 64'd0);
      check("rst_lpf_data", 64'(lpf_pixel_write), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      reset = 1'b0;
      tick(2);

      // 1: first pair, latency c+2, held until done_lpf
      pulse_ff();
      expect_wr(0, 0, 36'h000040002);
      px(18'h00001);
      c = cyc;
      px(18'h00002);
      tick(3);
      check("t1_latency", 64'(last_flag_cyc), 64'(c + 2));
      check("t1_flag_dropped", 64'(lpf_flag), 64'd0);
      tick(4);
      man_done = 1'b1;
      tick(1);
      man_done = 1'b0;
      tick(3);
      check("t1_writes", 64'(flag_cnt), 64'd1);
      check("t1_drained", 64'(exp_q.size()), 64'd0);

      // 2: one full line plus the first pair of line 1, acks 3 cycles after request
      pulse_ff();
      auto_ack  = 1'b1;
      ack_delay = 3;
      fc0 = flag_cnt;
      for (int i = 0; i < WIDTH + 2; i++) begin
         if (i % 2 == 1) expect_wr((i - 1) % WIDTH, (i - 1) / WIDTH, {pv(i - 1), pv(i)});
         px(pv(i));
         tick(2);
      end
      wait_drain("t2_drain", 200);
      check("t2_writes", 64'(flag_cnt - fc0), 64'd321);
      check("t2_overflow", 64'(overflow), 64'd0);

      // 3: overflow with acks withheld, then simultaneous push and pop on a full FIFO
      pulse_ff();
      auto_ack = 1'b0;
      fc0 = flag_cnt;
      for (int k = 0; k < 4; k++) expect_wr(2 * k, 0, {pv(100 + 2 * k), pv(101 + 2 * k)});
      for (int i = 0; i < 12; i++) px(pv(100 + i));
      tick(1);
      check("t3_overflow_set", 64'(overflow), 64'd1);
      check("t3_one_issued", 64'(flag_cnt - fc0), 64'd1);
      expect_wr(12, 0, {pv(112), pv(113)});
      px(pv(112));
      man_done = 1'b1;
      px(pv(113));
      man_done = 1'b0;
      auto_ack  = 1'b1;
      ack_delay = 2;
      wait_drain("t3_drain", 100);
      check("t3_writes", 64'(flag_cnt - fc0), 64'd5);
      check("t3_overflow_sticky", 64'(overflow), 64'd1);

      // 4: complete frame with prompt acks, extra pixels afterwards ignored
      pulse_ff();
      ack_delay = 1;
      fc0 = flag_cnt;
      fd0 = fd_cnt;
      for (int i = 0; i < WIDTH * HEIGHT; i++) begin
         if (i % 2 == 1) expect_wr((i - 1) % WIDTH, (i - 1) / WIDTH, {pv(2000 + i - 1), pv(2000 + i)});
         px(pv(2000 + i));
         tick(1);
      end
      for (int i = 0; i < 4; i++) px(pv(9000 + i));
      n = 0;
      while (fd_cnt == fd0 && n < 200) begin
         tick(1);
         n++;
      end
      check("t4_frame_done_seen", 64'(fd_cnt - fd0), 64'd1);
      check("t4_all_acked", 64'(exp_q.size()), 64'd0);
      tick(10);
      check("t4_writes", 64'(flag_cnt - fc0), 64'd1280);
      check("t4_single_pulse", 64'(fd_cnt - fd0), 64'd1);
      check("t4_overflow", 64'(overflow), 64'd0);

      // 5: frame_flag during WAIT with a queue and trailing half-word; pixel in same cycle lost
      pulse_ff();
      auto_ack = 1'b0;
      fc0 = flag_cnt;
      expect_wr(0, 0, {pv(300), pv(301)});
      for (int i = 0; i < 13; i++) px(pv(300 + i));
      tick(1);
      check("t5_overflow_set", 64'(overflow), 64'd1);
      check("t5_one_issued", 64'(flag_cnt - fc0), 64'd1);
      pixel      = 18'h3ffff;
      pixel_flag = 1'b1;
      frame_flag = 1'b1;
      tick(1);
      pixel_flag = 1'b0;
      frame_flag = 1'b0;
      tick(1);
      check("t5_overflow_cleared", 64'(overflow), 64'd0);
      check("t5_data_held", 64'(lpf_pixel_write), 64'({pv(300), pv(301)}));
      tick(3);
      man_done = 1'b1;
      tick(1);
      man_done = 1'b0;
      tick(6);
      check("t5_no_more_writes", 64'(flag_cnt - fc0), 64'd1);
      expect_wr(0, 0, {18'h0aaaa, 18'h15555});
      auto_ack = 1'b1;
      px(18'h0aaaa);
      px(18'h15555);
      wait_drain("t5_drain", 50);
      check("t5_writes", 64'(flag_cnt - fc0), 64'd2);

      // 6: asynchronous reset while a write is outstanding
      auto_ack = 1'b0;
      fc0 = flag_cnt;
      expect_wr(2, 0, {pv(400), pv(401)});
      px(pv(400));
      px(pv(401));
      tick(4);
      check("t6_issued", 64'(flag_cnt - fc0), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("t6_async_lpf_wr", 64'(lpf_wr), 64'd0);
      check("t6_async_lpf_x", 64'(lpf_x), 64'd0);
      check("t6_async_lpf_y", 64'(lpf_y), 64'd0);
      check("t6_async_lpf_data", 64'(lpf_pixel_write), 64'd0);
      check("t6_async_overflow", 64'(overflow), 64'd0);
      @(posedge clock);
      #1;
      tick(1);
      reset = 1'b0;
      man_done = 1'b1;
      tick(1);
      man_done = 1'b0;
      tick(6);
      check("t6_late_done_ignored", 64'(flag_cnt - fc0), 64'd1);
      check("t6_flag_low", 64'(lpf_flag), 64'd0);
      check("t6_frame_done_low", 64'(fd_cnt), 64'(fd0 + 1));
      expect_wr(0, 0, {pv(410), pv(411)});
      auto_ack  = 1'b1;
      ack_delay = 2;
      px(pv(410));
      px(pv(411));
      wait_drain("t6_drain", 50);
      check("t6_writes", 64'(flag_cnt - fc0), 64'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
